// File: rtl/paicore_send_mc.sv
// paicore_send_mc
// Downstream send path to PAICORE: AXI-Stream words are counted into frames,
// buffered as {last,data} in a small FIFO, then each word is serialised into
// DATA_W/OUT_W beats on a 4-phase req/ack bus. The acknowledge comes straight
// from the chip pins, so it is resynchronised before the handshake FSM uses it.
module paicore_send_mc #(
    parameter int DATA_W      = 64,
    parameter int OUT_W       = 32,
    parameter int LEN_W       = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          s_axis_aclk,
    input  logic                          s_axis_areset,
    input  logic [LEN_W-1:0]              send_len,
    output logic [LEN_W-1:0]              data_cnt,
    output logic [LEN_W-1:0]              tlast_cnt,
    output logic                          s_axis_tready,
    input  logic [DATA_W-1:0]             s_axis_tdata,
    input  logic                          s_axis_tlast,
    input  logic                          s_axis_tvalid,
    output logic                          write_hsked,
    output logic [DATA_W-1:0]             write_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          snn_in_hsked,
    input  logic                          acknowledge,
    output logic                          request,
    output logic [OUT_W-1:0]              dout,
    output logic                          tx_busy,
    output logic                          o_tx_done
);

    localparam int BEATS = DATA_W / OUT_W;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [LW-1:0]    FULL_LVL  = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0]    LVL_ONE   = LW'(1);
    localparam logic [BW-1:0]    LAST_BEAT = BW'(BEATS - 1);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Extract beat number idx of a word, least-significant slice first.
    function automatic logic [OUT_W-1:0] beat_slice(input logic [DATA_W-1:0] w,
                                                    input int unsigned idx);
        logic [DATA_W-1:0] sh;
        sh = w >> (idx * OUT_W);
        return sh[OUT_W-1:0];
    endfunction

    logic clk;
    logic rst;
    assign clk = s_axis_aclk;
    assign rst = s_axis_areset;

    // ------------------------------------------------------------------
    // Input side: frame counting
    // ------------------------------------------------------------------
    logic [LEN_W-1:0] data_cnt_q, data_cnt_d;
    logic [LEN_W-1:0] tlast_cnt_q, tlast_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] len_eff;
    logic             in_hsk;
    logic             in_last;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;

    // Ready is held low through reset so nothing is accepted into a flushing FIFO.
    assign s_axis_tready = ~fifo_full & ~rst;
    assign in_hsk        = s_axis_tvalid & s_axis_tready;
    assign write_hsked   = in_hsk;
    assign write_data    = s_axis_tdata;
    assign data_cnt      = data_cnt_q;
    assign tlast_cnt     = tlast_cnt_q;

    // Frame length is captured from send_len only on the first word of a frame.
    always_comb begin
        len_eff = len_q;
        if (data_cnt_q == '0) begin
            len_eff = (send_len == '0) ? LEN_ONE : send_len;
        end
        in_last     = s_axis_tlast | (data_cnt_q == (len_eff - LEN_ONE));
        data_cnt_d  = data_cnt_q;
        tlast_cnt_d = tlast_cnt_q;
        len_d       = len_q;
        if (in_hsk) begin
            len_d = len_eff;
            if (in_last) begin
                data_cnt_d  = '0;
                tlast_cnt_d = tlast_cnt_q + LEN_ONE;
            end else begin
                data_cnt_d  = data_cnt_q + LEN_ONE;
            end
        end
    end

    // Frame counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_cnt_q  <= '0;
            tlast_cnt_q <= '0;
            len_q       <= '0;
        end else begin
            data_cnt_q  <= data_cnt_d;
            tlast_cnt_q <= tlast_cnt_d;
            len_q       <= len_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO of {last, data}
    // ------------------------------------------------------------------
    logic [DATA_W:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [DATA_W:0]   fifo_rdata;

    assign fifo_full  = (level_q == FULL_LVL);
    assign fifo_empty = (level_q == '0);
    assign fifo_rdata = mem[rd_ptr_q];
    assign fifo_level = level_q;

    // Pointer and occupancy update; simultaneous push and pop leave level unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (in_hsk) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({in_hsk, fifo_pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // FIFO control registers; reset flushes by clearing pointers and level.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (in_hsk) begin
            mem[wr_ptr_q] <= {in_last, s_axis_tdata};
        end
    end

    // ------------------------------------------------------------------
    // Acknowledge synchroniser
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                   ack_s;

    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    // Shift the asynchronous acknowledge through SYNC_STAGES flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], acknowledge};
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              last_q, last_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              request_q, request_d;
    logic [OUT_W-1:0]  dout_q, dout_d;
    logic              snn_pulse;
    logic              done_pulse;

    assign request      = request_q;
    assign dout         = dout_q;
    assign tx_busy      = (state_q != ST_IDLE);
    assign snn_in_hsked = snn_pulse & ~rst;
    assign o_tx_done    = done_pulse & ~rst;

    // Next state: request and dout are registered and only change on REQ entry
    // (dout) or REQ/DROP transitions (request); a new word is never started
    // while the synchronised acknowledge is still high.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        last_d     = last_q;
        beat_d     = beat_q;
        request_d  = request_q;
        dout_d     = dout_q;
        fifo_pop   = 1'b0;
        snn_pulse  = 1'b0;
        done_pulse = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !ack_s) begin
                    fifo_pop  = 1'b1;
                    snn_pulse = 1'b1;
                    word_d    = fifo_rdata[DATA_W-1:0];
                    last_d    = fifo_rdata[DATA_W];
                    beat_d    = '0;
                    request_d = 1'b1;
                    dout_d    = beat_slice(fifo_rdata[DATA_W-1:0], 0);
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    request_d = 1'b0;
                    state_d   = ST_DROP;
                end
            end
            ST_DROP: begin
                if (!ack_s) begin
                    if (beat_q == LAST_BEAT) begin
                        done_pulse = last_q;
                        state_d    = ST_IDLE;
                    end else begin
                        beat_d    = beat_q + BW'(1);
                        request_d = 1'b1;
                        dout_d    = beat_slice(word_q, 32'(beat_q) + 32'd1);
                        state_d   = ST_REQ;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Serialiser state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            word_q    <= '0;
            last_q    <= 1'b0;
            beat_q    <= '0;
            request_q <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            last_q    <= last_d;
            beat_q    <= beat_d;
            request_q <= request_d;
            dout_q    <= dout_d;
        end
    end

endmodule

// File: tb/tb_paicore_send_mc.sv
// Testbench for paicore_send_mc: directed frames with a chip-side ack
// responder and a transaction-level reference model of frames and beats.
`timescale 1ns/1ps
module tb_paicore_send_mc;

    localparam int DATA_W      = 64;
    localparam int OUT_W       = 32;
    localparam int LEN_W       = 32;
    localparam int FIFO_DEPTH  = 16;
    localparam int SYNC_STAGES = 2;
    localparam int BEATS       = DATA_W / OUT_W;
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [LEN_W-1:0]  send_len = 32'd4;
    logic [LEN_W-1:0]  data_cnt;
    logic [LEN_W-1:0]  tlast_cnt;
    logic              s_axis_tready;
    logic [DATA_W-1:0] s_axis_tdata = '0;
    logic              s_axis_tlast = 1'b0;
    logic              s_axis_tvalid = 1'b0;
    logic              write_hsked;
    logic [DATA_W-1:0] write_data;
    logic [LVL_W-1:0]  fifo_level;
    logic              snn_in_hsked;
    logic              acknowledge = 1'b0;
    logic              request;
    logic [OUT_W-1:0]  dout;
    logic              tx_busy;
    logic              o_tx_done;

    always #5 clk = ~clk;

    paicore_send_mc #(
        .DATA_W(DATA_W), .OUT_W(OUT_W), .LEN_W(LEN_W),
        .FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .s_axis_aclk(clk), .s_axis_areset(rst), .send_len(send_len),
        .data_cnt(data_cnt), .tlast_cnt(tlast_cnt), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
        .write_hsked(write_hsked), .write_data(write_data), .fifo_level(fifo_level),
        .snn_in_hsked(snn_in_hsked), .acknowledge(acknowledge), .request(request),
        .dout(dout), .tx_busy(tx_busy), .o_tx_done(o_tx_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference model state: expected beats in send order, plus frame counters.
    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             done;
        logic [7:0]       idx;
    } beat_t;

    beat_t            bq[$];
    beat_t            cur;
    bit               have_cur  = 0;
    bit               dropped   = 0;
    logic [LEN_W-1:0] m_cnt     = '0;
    logic [LEN_W-1:0] m_tl      = '0;
    logic [LEN_W-1:0] m_len     = '0;
    int               pushed    = 0;
    int               popped    = 0;
    logic             prev_req  = 1'b0;
    logic             prev_snn  = 1'b0;
    logic             prev_acks = 1'b0;
    logic             a1        = 1'b0;
    logic             a2        = 1'b0;
    int               rise_cnt  = 0;
    int               done_cnt  = 0;
    int               ack_mode  = 0;   // 0 echo request after 3 cycles, 1 force low, 2 force high

    // Chip-side responder on the acknowledge pin.
    initial begin : ack_drv
        logic [2:0] hist;
        hist = 3'b000;
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                0:       acknowledge = hist[2];
                1:       acknowledge = 1'b0;
                default: acknowledge = 1'b1;
            endcase
            hist = {hist[1:0], request};
        end
    end

    // Compare process: every cycle, DUT outputs against the reference model.
    always @(negedge clk) begin : monitor
        logic acks;
        logic rise;
        logic rise0;
        logic exp_done;
        logic lst;
        beat_t b;
        acks = a2;
        a2   = a1;
        a1   = acknowledge;
        if (rst) begin
            chk("rst_tready", 64'(s_axis_tready), 64'd0);
            chk("rst_hsked", 64'(write_hsked), 64'd0);
            chk("rst_tx_done", 64'(o_tx_done), 64'd0);
            chk("rst_snn", 64'(snn_in_hsked), 64'd0);
            bq.delete();
            have_cur = 0; dropped = 0; pushed = 0; popped = 0;
            m_cnt = '0; m_tl = '0; m_len = '0;
            prev_req = 1'b0; prev_snn = 1'b0; prev_acks = 1'b0;
            a1 = 1'b0; a2 = 1'b0;
        end else begin
            rise  = request && !prev_req;
            rise0 = 1'b0;
            if (rise) begin
                chk("req_rise_ack_low", 64'(prev_acks), 64'd0);
                if (bq.size() == 0) begin
                    chk("unexpected_req", 64'(request), 64'd0);
                end else begin
                    cur = bq.pop_front();
                    have_cur = 1; dropped = 0;
                    rise_cnt++;
                    if (cur.idx == 8'd0) begin
                        popped++;
                        rise0 = 1'b1;
                    end
                end
            end
            chk("snn_to_req", 64'(rise0), 64'(prev_snn));
            if (have_cur) chk("dout", 64'(dout), 64'(cur.data));
            chk("tx_busy", 64'(tx_busy), 64'(have_cur));
            exp_done = 1'b0;
            if (have_cur && !request && prev_req) begin
                chk("req_fall_ack_high", 64'(prev_acks), 64'd1);
                dropped = 1;
            end
            if (dropped && !acks) begin
                exp_done = cur.done;
                have_cur = 0; dropped = 0;
            end
            chk("tx_done", 64'(o_tx_done), 64'(exp_done));
            if (o_tx_done) done_cnt++;
            chk("data_cnt", 64'(data_cnt), 64'(m_cnt));
            chk("tlast_cnt", 64'(tlast_cnt), 64'(m_tl));
            chk("fifo_level", 64'(fifo_level), 64'(pushed - popped));
            chk("write_hsked", 64'(write_hsked), 64'(s_axis_tvalid & s_axis_tready));
            if (s_axis_tvalid && s_axis_tready) begin
                chk("write_data", write_data, s_axis_tdata);
                if (m_cnt == '0) m_len = (send_len == '0) ? 32'd1 : send_len;
                lst = s_axis_tlast || ((m_cnt + 32'd1) == m_len);
                if (lst) begin
                    m_cnt = '0;
                    m_tl  = m_tl + 32'd1;
                end else begin
                    m_cnt = m_cnt + 32'd1;
                end
                for (int i = 0; i < BEATS; i++) begin
                    b.data = s_axis_tdata[i*OUT_W +: OUT_W];
                    b.done = lst && (i == BEATS - 1);
                    b.idx  = 8'(i);
                    bq.push_back(b);
                end
                pushed++;
            end
            prev_req  = request;
            prev_snn  = snn_in_hsked;
            prev_acks = acks;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until accepted (bounded).
    task automatic send_word(input logic [DATA_W-1:0] d, input logic l);
        int  n;
        logic hs;
        n  = 0;
        hs = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        while (!hs && n < 2000) begin
            @(negedge clk);
            hs = s_axis_tready && !rst;
            tick();
            n++;
        end
        if (!hs) chk("send_accept", 64'(hs), 64'd1);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Wait until every expected beat has gone out and the serialiser is idle (bounded).
    task automatic wait_drain(input string name);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 3000 && !ok; n++) begin
            @(negedge clk);
            if (bq.size() == 0 && !have_cur && !tx_busy && fifo_level == '0) ok = 1'b1;
            tick();
        end
        chk(name, 64'(ok), 64'd1);
    endtask

    initial begin : watchdog
        #500000;
        failures++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : main
        int r0;
        int d0;
        logic found;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("init_request", 64'(request), 64'd0);
        chk("init_dout", 64'(dout), 64'd0);
        chk("init_level", 64'(fifo_level), 64'd0);
        chk("init_data_cnt", 64'(data_cnt), 64'd0);
        chk("init_tlast_cnt", 64'(tlast_cnt), 64'd0);
        chk("init_tready", 64'(s_axis_tready), 64'd1);
        chk("init_busy", 64'(tx_busy), 64'd0);
        tick();

        // 1: four-word frame, ack echo, LS half first, latency N -> N+2
        send_len = 32'd4;
        r0 = rise_cnt; d0 = done_cnt;
        send_word(64'h0000_0002_0000_0001, 1'b0);
        chk("t1_snn_n1", 64'(snn_in_hsked), 64'd1);
        chk("t1_req_n1", 64'(request), 64'd0);
        tick();
        chk("t1_req_n2", 64'(request), 64'd1);
        chk("t1_dout_ls", 64'(dout), 64'h0000_0001);
        send_word(64'h0000_0004_0000_0003, 1'b0);
        chk("t1_cnt2", 64'(data_cnt), 64'd2);
        send_word(64'h0000_0006_0000_0005, 1'b0);
        send_word(64'h0000_0008_0000_0007, 1'b0);
        chk("t1_cnt_wrap", 64'(data_cnt), 64'd0);
        wait_drain("t1_drain");
        chk("t1_beats", 64'(rise_cnt - r0), 64'd8);
        chk("t1_done", 64'(done_cnt - d0), 64'd1);
        chk("t1_tlast_cnt", 64'(tlast_cnt), 64'd1);

        // 2: tlast closes frame early, next frame re-latches length
        send_len = 32'd10;
        r0 = rise_cnt; d0 = done_cnt;
        send_word(64'h1111_0002_1111_0001, 1'b0);
        send_word(64'h1111_0004_1111_0003, 1'b0);
        chk("t2_cnt2", 64'(data_cnt), 64'd2);
        send_word(64'h1111_0006_1111_0005, 1'b1);
        chk("t2_cnt_close", 64'(data_cnt), 64'd0);
        chk("t2_tlast_cnt", 64'(tlast_cnt), 64'd2);
        wait_drain("t2_drain");
        chk("t2_beats", 64'(rise_cnt - r0), 64'd6);
        chk("t2_done", 64'(done_cnt - d0), 64'd1);
        send_len = 32'd2;
        d0 = done_cnt;
        send_word(64'h2222_0002_2222_0001, 1'b0);
        chk("t2b_cnt1", 64'(data_cnt), 64'd1);
        send_word(64'h2222_0004_2222_0003, 1'b0);
        chk("t2b_cnt0", 64'(data_cnt), 64'd0);
        chk("t2b_tlast_cnt", 64'(tlast_cnt), 64'd3);
        wait_drain("t2b_drain");
        chk("t2b_done", 64'(done_cnt - d0), 64'd1);

        // 3: ack held low, 17 words fill serialiser + FIFO, then drain in order
        ack_mode = 1;
        send_len = 32'd100;
        r0 = rise_cnt; d0 = done_cnt;
        for (int i = 0; i < 17; i++) begin
            send_word({32'h3000_0000 + 32'(i), 32'h0300_0000 + 32'(i)}, i == 16);
        end
        tick(); tick(); tick();
        chk("t3_level_full", 64'(fifo_level), 64'd16);
        chk("t3_tready_low", 64'(s_axis_tready), 64'd0);
        chk("t3_req_wait", 64'(request), 64'd1);
        chk("t3_dout_first", 64'(dout), 64'h0300_0000);
        chk("t3_tlast_cnt", 64'(tlast_cnt), 64'd4);
        ack_mode = 0;
        wait_drain("t3_drain");
        chk("t3_beats", 64'(rise_cnt - r0), 64'd34);
        chk("t3_done", 64'(done_cnt - d0), 64'd1);

        // 4: send_len change mid-frame applies only to the following frame
        send_len = 32'd4;
        d0 = done_cnt;
        send_word(64'h4444_0002_4444_0001, 1'b0);
        send_len = 32'd2;
        send_word(64'h4444_0004_4444_0003, 1'b0);
        chk("t4_cnt2", 64'(data_cnt), 64'd2);
        send_word(64'h4444_0006_4444_0005, 1'b0);
        chk("t4_cnt3", 64'(data_cnt), 64'd3);
        send_word(64'h4444_0008_4444_0007, 1'b0);
        chk("t4_cnt_close", 64'(data_cnt), 64'd0);
        chk("t4_tlast_a", 64'(tlast_cnt), 64'd5);
        send_word(64'h5555_0002_5555_0001, 1'b0);
        chk("t4_cnt1", 64'(data_cnt), 64'd1);
        send_word(64'h5555_0004_5555_0003, 1'b0);
        chk("t4_tlast_b", 64'(tlast_cnt), 64'd6);
        wait_drain("t4_drain");
        chk("t4_done", 64'(done_cnt - d0), 64'd2);

        // 5: reset while request is high
        send_len = 32'd4;
        send_word(64'h6666_0002_6666_0001, 1'b0);
        send_word(64'h6666_0004_6666_0003, 1'b0);
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            if (request) found = 1'b1;
            else tick();
        end
        chk("t5_req_seen", 64'(found), 64'd1);
        d0 = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t5_request", 64'(request), 64'd0);
        chk("t5_dout", 64'(dout), 64'd0);
        chk("t5_level", 64'(fifo_level), 64'd0);
        chk("t5_data_cnt", 64'(data_cnt), 64'd0);
        chk("t5_tlast_cnt", 64'(tlast_cnt), 64'd0);
        chk("t5_busy", 64'(tx_busy), 64'd0);
        repeat (30) tick();
        chk("t5_no_done", 64'(done_cnt - d0), 64'd0);

        // 6: acknowledge high across reset release, FIFO loaded, request held off
        ack_mode = 2;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        repeat (4) tick();
        send_len = 32'd2;
        r0 = rise_cnt; d0 = done_cnt;
        send_word(64'h7777_0002_7777_0001, 1'b0);
        send_word(64'h7777_0004_7777_0003, 1'b0);
        for (int n = 0; n < 8; n++) begin
            tick();
            chk("t6_req_hold", 64'(request), 64'd0);
        end
        chk("t6_level", 64'(fifo_level), 64'd2);
        chk("t6_tlast_cnt", 64'(tlast_cnt), 64'd1);
        ack_mode = 0;
        wait_drain("t6_drain");
        chk("t6_beats", 64'(rise_cnt - r0), 64'd4);
        chk("t6_done", 64'(done_cnt - d0), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
